mfcc_delta: RTL and testbench

//  Downstream of dct: consumes the per-frame cepstral stream (valid/ptr/data + frame-done pulse).

---
 rtl/mfcc_delta.sv | 144 ++++++++++++++
 tb/tb_mfcc_delta.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mfcc_delta.sv
// Cepstral delta stage: a ring of recent frames feeds a two-stage pipeline that emits the centre
// frame's static coefficient and its regression delta, one coefficient per cycle.
module mfcc_delta #(
  parameter int NUM_CEPS   = 12,
  parameter int CEPS_WIDTH = 16,
  parameter int DELTA_N    = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  input  logic [$clog2(NUM_CEPS)-1:0]   ceps_ptr_i,
  input  logic signed [CEPS_WIDTH-1:0]  ceps_in,
  input  logic                          frame_done_i,
  output logic                          out_valid_o,
  output logic [$clog2(NUM_CEPS)-1:0]   out_ptr_o,
  output logic signed [CEPS_WIDTH-1:0]  ceps_o,
  output logic signed [CEPS_WIDTH-1:0]  delta_o,
  output logic                          done_o,
  output logic                          busy_o,
  output logic                          overrun_o
);
  localparam int HIST  = 2*DELTA_N + 2;
  localparam int TAPS  = 2*DELTA_N + 1;
  localparam int PW    = $clog2(NUM_CEPS);
  localparam int SW    = $clog2(HIST);
  localparam int ACCW  = CEPS_WIDTH + 5;
  localparam int PRW   = ACCW + 17;
  localparam int RECIP = (DELTA_N == 1) ? 16384 : (DELTA_N == 2) ? 3277 : 1170;
  localparam int MAXV  = 2**(CEPS_WIDTH-1) - 1;
  localparam int MINV  = -(2**(CEPS_WIDTH-1));

  typedef enum logic [1:0] {IDLE, COMPUTE, FLUSH, DONE} state_t;

  state_t          state;
  logic [SW-1:0]   wr_slot, wr_nxt, newest, held, held_nxt;
  logic [PW-1:0]   k, rd_ptr;
  logic            req_q, pending;
  logic [2:1]      vld_pipe;

  logic signed [CEPS_WIDTH-1:0] ring [HIST][NUM_CEPS];
  logic signed [CEPS_WIDTH-1:0] rd_c [TAPS];
  logic [SW-1:0]                tap_slot [TAPS];

  logic signed [ACCW-1:0]       acc;
  logic signed [PRW-1:0]        prod, rnd;
  logic signed [CEPS_WIDTH-1:0] dsat;

  function automatic logic [SW-1:0] slot_back(input logic [SW-1:0] s, input int d);
    int t;
    t = int'(s) - d;
    if (t < 0) t = t + HIST;
    return SW'(t);
  endfunction

  assign wr_nxt      = (wr_slot == SW'(HIST-1)) ? '0 : wr_slot + 1'b1;
  assign held_nxt    = (held == SW'(TAPS)) ? held : held + 1'b1;
  assign out_valid_o = vld_pipe[2];

  // tap j holds frame newest-j, so the centre is tap DELTA_N
  always_comb begin
    for (int j = 0; j < TAPS; j++) tap_slot[j] = slot_back(newest, j);
  end

  // The slot being filled is never among the taps, so writes are safe in any state.
  always_ff @(posedge clk) begin
    if (in_valid && (int'(ceps_ptr_i) < NUM_CEPS)) ring[wr_slot][ceps_ptr_i] <= ceps_in;
    for (int j = 0; j < TAPS; j++) rd_c[j] <= ring[tap_slot[j]][k];
  end

  always_comb begin
    acc = '0;
    for (int n = 1; n <= DELTA_N; n++)
      acc = acc + ACCW'(n) * (ACCW'(rd_c[DELTA_N-n]) - ACCW'(rd_c[DELTA_N+n]));
    prod = PRW'(acc) * PRW'(RECIP);
    rnd  = (prod + PRW'(16384)) >>> 15;
    if (rnd > PRW'(MAXV))      dsat = CEPS_WIDTH'(MAXV);
    else if (rnd < PRW'(MINV)) dsat = CEPS_WIDTH'(MINV);
    else                       dsat = CEPS_WIDTH'(rnd);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wr_slot   <= '0;
      held      <= '0;
      newest    <= '0;
      k         <= '0;
      rd_ptr    <= '0;
      req_q     <= 1'b0;
      pending   <= 1'b0;
      vld_pipe  <= '0;
      out_ptr_o <= '0;
      ceps_o    <= '0;
      delta_o   <= '0;
      done_o    <= 1'b0;
      busy_o    <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      req_q <= frame_done_i && (held_nxt == SW'(TAPS));
      if (frame_done_i) begin
        wr_slot <= wr_nxt;
        held    <= held_nxt;
      end
      done_o      <= 1'b0;
      vld_pipe[1] <= (state == COMPUTE);
      vld_pipe[2] <= vld_pipe[1];
      rd_ptr      <= k;
      if (vld_pipe[1]) begin
        out_ptr_o <= rd_ptr;
        ceps_o    <= rd_c[DELTA_N];
        delta_o   <= dsat;
      end
      case (state)
        IDLE: if (req_q || pending) begin
          state   <= COMPUTE;
          busy_o  <= 1'b1;
          k       <= '0;
          newest  <= slot_back(wr_slot, 1);
          pending <= req_q && pending;
        end
        COMPUTE: begin
          if (k == PW'(NUM_CEPS-1)) begin
            k     <= '0;
            state <= FLUSH;
          end else begin
            k <= k + 1'b1;
          end
        end
        FLUSH: state <= DONE;
        DONE: begin
          done_o <= 1'b1;
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // one request can wait; a second one while waiting is lost
      if (req_q && (state != IDLE)) begin
        if (pending) overrun_o <= 1'b1;
        else         pending   <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mfcc_delta.sv
// Randomized bench for mfcc_delta against a frame-ring reference model.
module tb_mfcc_delta;
  localparam int NC = 12;
  localparam int N  = 2;
  localparam int H  = 2*N + 2;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, frame_done_i;
  logic [3:0] ceps_ptr_i;
  logic signed [15:0] ceps_in;
  logic out_valid_o, done_o, busy_o, overrun_o;
  logic [3:0] out_ptr_o;
  logic signed [15:0] ceps_o, delta_o;

  always #5 clk = ~clk;

  mfcc_delta #(.NUM_CEPS(NC), .CEPS_WIDTH(16), .DELTA_N(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .ceps_ptr_i(ceps_ptr_i),
    .ceps_in(ceps_in), .frame_done_i(frame_done_i), .out_valid_o(out_valid_o),
    .out_ptr_o(out_ptr_o), .ceps_o(ceps_o), .delta_o(delta_o), .done_o(done_o),
    .busy_o(busy_o), .overrun_o(overrun_o)
  );

  typedef struct {int ptr; int ceps; int delta;} exp_t;
  exp_t expq[$];
  int n_chk = 0, n_pass = 0;
  int n_out = 0, n_done = 0, exp_done = 0;
  int last_ceps = 0, last_delta = 0;
  bit prev_v = 0;
  int prev_ptr = 0;
  int m_ring [H][NC];
  int m_wr = 0, m_held = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // frame-level reference: delta = round(sum n*(c[t+n]-c[t-n]) * RECIP / 2^15), saturated
  task automatic push_exp(input int nw);
    for (int k = 0; k < NC; k++) begin
      int c [2*N+1];
      longint acc, d;
      exp_t e;
      for (int j = 0; j <= 2*N; j++) c[j] = m_ring[(nw - j + H) % H][k];
      acc = 0;
      for (int n = 1; n <= N; n++) acc += n * (c[N-n] - c[N+n]);
      d = (acc * 3277 + 16384) >>> 15;
      if (d > 32767) d = 32767;
      if (d < -32768) d = -32768;
      e.ptr = k; e.ceps = c[N]; e.delta = int'(d);
      expq.push_back(e);
    end
  endtask

  task automatic mdl_done(output bit req);
    m_wr = (m_wr + 1) % H;
    if (m_held < 2*N+1) m_held++;
    req = (m_held == 2*N+1);
  endtask

  task automatic send_frame(input int mode, input int t);
    int v;
    bit req;
    logic signed [15:0] r;
    for (int k = 0; k < NC; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b1; ceps_ptr_i = 4'(12 + $urandom_range(0, 3));
        ceps_in = 16'($urandom); frame_done_i = 1'b0;
        tick();
      end
      r = 16'($urandom);
      case (mode)
        0: v = 500;
        1: v = 100 * t;
        2: v = -100 * t;
        4: v = (t < 2) ? -32768 : (t == 2) ? 1234 : 32767;
        default: v = int'(r);
      endcase
      in_valid = 1'b1; ceps_ptr_i = 4'(k); ceps_in = 16'(v); frame_done_i = (k == NC-1);
      tick();
      m_ring[m_wr][k] = v;
    end
    in_valid = 1'b0; frame_done_i = 1'b0;
    mdl_done(req);
    if (req) begin
      push_exp((m_wr + H - 1) % H);
      exp_done++;
      for (int i = 1; i <= 4; i++) begin
        @(negedge clk);
        chk("latency", out_valid_o, (i == 4));
      end
    end else begin
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 120 && expq.size() != 0; i++) @(negedge clk);
    chk("drain", expq.size(), 0);
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse_only(output bit req);
    frame_done_i = 1'b1; tick(); frame_done_i = 1'b0;
    mdl_done(req);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v = 1'b0;
    end else begin
      if (out_valid_o) begin
        n_out++;
        last_ceps = int'(ceps_o);
        last_delta = int'(delta_o);
        if (expq.size() == 0) begin
          chk("unexpected_out", 1, 0);
        end else begin
          exp_t e;
          e = expq.pop_front();
          chk("ptr", out_ptr_o, e.ptr);
          chk("ceps", int'(ceps_o), e.ceps);
          chk("delta", int'(delta_o), e.delta);
        end
      end
      if (done_o) begin
        n_done++;
        chk("done_after_last", (prev_v && prev_ptr == NC-1), 1);
      end
      prev_v = out_valid_o;
      prev_ptr = int'(out_ptr_o);
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout got=%0d exp=%0d", 0, 1);
    $fatal(1, "timeout");
  end

  initial begin
    bit r;
    int saved;
    rst_n = 1'b0; in_valid = 1'b0; frame_done_i = 1'b0; ceps_ptr_i = '0; ceps_in = '0;
    for (int s = 0; s < H; s++) for (int k = 0; k < NC; k++) m_ring[s][k] = 0;
    repeat (3) @(posedge clk); #1;
    chk("rst_valid", out_valid_o, 0);
    chk("rst_ceps", ceps_o, 0);
    chk("rst_delta", delta_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_overrun", overrun_o, 0);
    rst_n = 1'b1;
    tick();

    for (int t = 0; t < 5; t++) send_frame(0, t);
    wait_drain();
    chk("const_ceps", last_ceps, 500);
    chk("const_delta", last_delta, 0);
    chk("const_done", n_done, 1);

    for (int t = 0; t < 5; t++) send_frame(1, t);
    wait_drain();
    chk("ramp_ceps", last_ceps, 200);
    chk("ramp_delta", last_delta, 100);

    for (int t = 0; t < 5; t++) send_frame(2, t);
    wait_drain();
    chk("nramp_ceps", last_ceps, -200);
    chk("nramp_delta", last_delta, -100);

    for (int t = 0; t < 5; t++) send_frame(4, t);
    wait_drain();
    for (int t = 0; t < 8; t++) send_frame(3, t);
    wait_drain();
    chk("no_overrun_yet", overrun_o, 0);

    // three back-to-back requests: first runs, second waits, third is lost
    pulse_only(r);
    push_exp((m_wr + H - 1) % H); exp_done++;
    tick();
    pulse_only(r);
    tick();
    pulse_only(r);
    push_exp((m_wr + H - 1) % H); exp_done++;
    repeat (3) tick();
    chk("overrun_set", overrun_o, 1);
    chk("busy_mid", busy_o, 1);
    wait_drain();
    chk("done_count_pending", n_done, exp_done);

    // reset in the middle of a compute pass
    send_frame(3, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", out_valid_o, 0);
    chk("midrst_delta", delta_o, 0);
    chk("midrst_busy", busy_o, 0);
    chk("midrst_overrun", overrun_o, 0);
    expq.delete();
    exp_done--;
    m_wr = 0; m_held = 0;
    @(negedge clk);
    rst_n = 1'b1;
    saved = n_out;
    for (int t = 0; t < 4; t++) send_frame(3, t);
    chk("no_out_after_rst", n_out, saved);
    send_frame(3, 4);
    wait_drain();
    chk("out_after_rst", n_out, saved + NC);
    chk("done_count_final", n_done, exp_done);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
